// File: rtl/acq_frame_sequencer_if.sv
// Signal bundle between the acquisition frame sequencer (master) and the audio/FFT/display datapath (slave).
`timescale 1ns/1ps
interface acq_frame_sequencer_if;
    logic        freeze;
    logic        clr_status;
    logic        sample_valid;
    logic        fft_done;
    logic        start_acq;
    logic        time_en;
    logic        time_we;
    logic [9:0]  time_addr;
    logic        fft_start;
    logic        buf_sel;
    logic        frame_ready;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic        wdog_err;

    modport master (
        input  freeze, clr_status, sample_valid, fft_done,
        output start_acq, time_en, time_we, time_addr, fft_start, buf_sel,
               frame_ready, frame_cnt, overrun, wdog_err
    );

    modport slave (
        output freeze, clr_status, sample_valid, fft_done,
        input  start_acq, time_en, time_we, time_addr, fft_start, buf_sel,
               frame_ready, frame_cnt, overrun, wdog_err
    );
endinterface

// File: rtl/acq_frame_sequencer.sv
// Frame sequencer: acquisition tick, capture -> FFT -> ping-pong publish, overrun and freeze handling.
// Optional stall watchdog is compiled in with `define WATCHDOG_EN.
`timescale 1ns/1ps
module acq_frame_sequencer #(
    parameter int CLK_HZ    = 25_000_000,
    parameter int FRAME_HZ  = 10,
    parameter int FRAME_LEN = 1024,
    parameter int WDOG_CYC  = 4_000_000
) (
    input logic                   clk,
    input logic                   reset_n,
    acq_frame_sequencer_if.master bus
);
    localparam int PERIOD = CLK_HZ / FRAME_HZ;
    localparam int PRE_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PERIOD - 1);
    localparam logic [9:0]       ADDR_LAST = 10'(FRAME_LEN - 1);

    if (FRAME_LEN < 1 || FRAME_LEN > 1024 || (FRAME_LEN & (FRAME_LEN - 1)) != 0 || WDOG_CYC < 1)
    begin : g_param_check
        $error("acq_frame_sequencer: FRAME_LEN must be a power of 2 <= 1024 and WDOG_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, TRANSFORM, PUBLISH} state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             wdog_trip;
    logic             start_acq_q;
    logic             time_en_q;
    logic [9:0]       time_addr_q;
    logic             fft_start_q;
    logic             buf_sel_q;
    logic             frame_ready_q;
    logic [15:0]      frame_cnt_q;
    logic             overrun_q;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYC);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_err_q;
    logic            progress;

    // Progress = a sample landing in CAPTURE or the FFT finishing; IDLE/PUBLISH never stall.
    assign progress  = (state == IDLE) || (state == PUBLISH) ||
                       (state == CAPTURE && bus.sample_valid) ||
                       (state == TRANSFORM && bus.fft_done);
    assign wdog_trip = !progress && ((wdog_cnt + WD_W'(1)) == WD_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (progress || wdog_trip) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end
            if (wdog_trip) begin
                wdog_err_q <= 1'b1;
            end else if (bus.clr_status) begin
                wdog_err_q <= 1'b0;
            end
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_trip    = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            start_acq_q   <= 1'b0;
            time_en_q     <= 1'b0;
            time_addr_q   <= '0;
            fft_start_q   <= 1'b0;
            buf_sel_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            start_acq_q   <= 1'b0;
            fft_start_q   <= 1'b0;
            frame_ready_q <= 1'b0;

            // A tick while busy is dropped; setting overrun beats a simultaneous clear.
            if (tick && state != IDLE) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_status) begin
                overrun_q <= 1'b0;
            end

            if (wdog_trip) begin
                state     <= IDLE;
                time_en_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick && !bus.freeze) begin
                            state       <= CAPTURE;
                            time_addr_q <= '0;
                            time_en_q   <= 1'b1;
                            start_acq_q <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (bus.sample_valid) begin
                            if (time_addr_q == ADDR_LAST) begin
                                state       <= TRANSFORM;
                                time_addr_q <= '0;
                                time_en_q   <= 1'b0;
                                fft_start_q <= 1'b1;
                            end else begin
                                time_addr_q <= time_addr_q + 10'd1;
                            end
                        end
                    end
                    TRANSFORM: begin
                        if (bus.fft_done) begin
                            state         <= PUBLISH;
                            buf_sel_q     <= ~buf_sel_q;
                            frame_cnt_q   <= frame_cnt_q + 16'd1;
                            frame_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.start_acq   = start_acq_q;
    assign bus.time_en     = time_en_q;
    assign bus.time_we     = bus.sample_valid & time_en_q;
    assign bus.time_addr   = time_addr_q;
    assign bus.fft_start   = fft_start_q;
    assign bus.buf_sel     = buf_sel_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.overrun     = overrun_q;
endmodule
